booth_radix4_mult: RTL and testbench

Sequential radix-4 Booth multiplier, parametrised in operand width. It supports signed or unsigned operands, selected per transaction. Each iteration retires two multiplier bits, so one product takes N/2+1 compute cycles. The block sits in the arithmetic datapath and uses a valid/ready handshake on both input and output, so producers and consumers can stall it.

---
 rtl/booth_radix4_mult_pkg.sv | 24 ++
 rtl/booth_radix4_mult_if.sv | 24 ++
 rtl/booth_radix4_mult_encoder.sv | 21 ++
 rtl/booth_radix4_mult.sv | 127 ++++++++++++
 tb/tb_booth_radix4_mult.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/booth_radix4_mult_pkg.sv
// rtl/booth_radix4_mult_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  // Radix-4 Booth digit: 0, +M, +2M, -M, -2M
  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    NM,
    N2M
  } digit_t;

  // Compute cycles per product: N+2 extended multiplier bits retired two at a time
  function automatic int booth_iters(input int n);
    return n / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_radix4_mult_if.sv
// rtl/booth_radix4_mult_if.sv - operand/product handshake bundle for the Booth multiplier
interface booth_radix4_mult_if #(
  parameter int N = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] c;
  logic           busy;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, c, busy
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, c, busy
  );
endinterface

// File: rtl/booth_radix4_mult_encoder.sv
// rtl/booth_radix4_mult_encoder.sv - maps a 3-bit Booth window to a radix-4 digit
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0] i_window,
  output digit_t     o_digit
);

  // Window is {Q[1], Q[0], Q[-1]}
  always_comb begin
    o_digit = ZERO;
    case (i_window)
      3'b001, 3'b010: o_digit = PM;
      3'b011:         o_digit = P2M;
      3'b100:         o_digit = N2M;
      3'b101, 3'b110: o_digit = NM;
      default:        o_digit = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_radix4_mult.sv
// rtl/booth_radix4_mult.sv - sequential radix-4 Booth multiplier with valid/ready handshakes
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input logic               clk,
  input logic               rst,
  booth_radix4_mult_if.slave bus
);

  localparam int ITERS = booth_iters(N);
  localparam int CW    = $clog2(ITERS + 1);
  localparam int QW    = N + 2;
  localparam int AW    = N + 4;

  state_t                r_state;
  state_t                w_next_state;
  logic [CW-1:0]         r_cnt;
  logic [QW-1:0]         r_m;
  logic [QW-1:0]         r_q;
  logic                  r_q_m1;
  logic signed [AW-1:0]  r_a;
  logic [2*N-1:0]        r_c;

  digit_t                w_digit;
  logic signed [AW-1:0]  w_m_ext;
  logic signed [AW-1:0]  w_addend;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW+QW:0] w_cat;
  logic signed [AW+QW:0] w_shifted;
  logic [QW-1:0]         w_a_ext;
  logic [QW-1:0]         w_b_ext;

  assign w_a_ext = bus.is_signed ? {{2{bus.a[N-1]}}, bus.a} : {2'b00, bus.a};
  assign w_b_ext = bus.is_signed ? {{2{bus.b[N-1]}}, bus.b} : {2'b00, bus.b};
  assign w_m_ext = {{2{r_m[QW-1]}}, r_m};

  booth_r4_encoder u_encoder (
    .i_window ({r_q[1:0], r_q_m1}),
    .o_digit  (w_digit)
  );

  // Select digit*M; the accumulator has headroom for +/-2M without overflow
  always_comb begin
    w_addend = '0;
    case (w_digit)
      PM:      w_addend = w_m_ext;
      P2M:     w_addend = w_m_ext <<< 1;
      NM:      w_addend = -w_m_ext;
      N2M:     w_addend = -(w_m_ext <<< 1);
      default: w_addend = '0;
    endcase
  end

  assign w_sum     = r_a + w_addend;
  assign w_cat     = {w_sum, r_q, r_q_m1};
  assign w_shifted = w_cat >>> 2;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and handshake outputs; COMPUTE ends with one extra cycle that latches c
  always_comb begin
    w_next_state  = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) w_next_state = COMPUTE;
      end
      COMPUTE: begin
        bus.busy = 1'b1;
        if (r_cnt == '0) w_next_state = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture, one Booth step per COMPUTE cycle, product latch on leaving COMPUTE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_m    <= '0;
      r_q    <= '0;
      r_q_m1 <= 1'b0;
      r_a    <= '0;
      r_c    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_m    <= w_a_ext;
            r_q    <= w_b_ext;
            r_q_m1 <= 1'b0;
            r_a    <= '0;
            r_cnt  <= CW'(ITERS);
          end
        end
        COMPUTE: begin
          if (r_cnt != '0) begin
            r_a    <= w_shifted[AW+QW:QW+1];
            r_q    <= w_shifted[QW:1];
            r_q_m1 <= w_shifted[0];
            r_cnt  <= r_cnt - 1'b1;
          end else begin
            r_c <= {r_a[N-3:0], r_q};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.c = r_c;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// tb/tb_booth_radix4_mult.sv - scoreboard bench for booth_radix4_mult at N=8 and N=32
module tb_booth_radix4_mult;

  localparam int NRAND = 1500;
  localparam int BOUND = 80000;

  logic clk;
  logic rst;

  booth_radix4_mult_if #(.N(8))  if8 ();
  booth_radix4_mult_if #(.N(32)) if32 ();

  booth_radix4_mult #(.N(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  booth_radix4_mult #(.N(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] q8[$];
  logic [63:0] q32[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic s, input int n);
    logic [63:0] xe, ye, p;
    xe = 64'(x);
    ye = 64'(y);
    if (s) begin
      for (int i = n; i < 64; i++) begin
        xe[i] = x[n-1];
        ye[i] = y[n-1];
      end
    end
    p = xe * ye;
    if (n < 32) p = p & ((64'd1 << (2 * n)) - 64'd1);
    return p;
  endfunction

  task automatic do8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                     input logic [15:0] exp, input int hold, input string tag);
    int lat;
    logic [63:0] e;
    q8.push_back(64'(exp));
    chk({tag, "_in_ready"}, 64'(if8.in_ready), 64'd1);
    if8.a = ta;
    if8.b = tb;
    if8.is_signed = ts;
    if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if8.a = ~ta;
    if8.b = ~tb;
    if8.is_signed = ~ts;
    chk({tag, "_busy"}, 64'(if8.busy), 64'd1);
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd6);
    e = q8.pop_front();
    chk({tag, "_c"}, 64'(if8.c), e);
    for (int i = 0; i < hold; i++) begin
      if8.in_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 64'(if8.out_valid), 64'd1);
      chk({tag, "_hold_c"}, 64'(if8.c), e);
      chk({tag, "_hold_in_ready"}, 64'(if8.in_ready), 64'd0);
    end
    if8.in_valid = 1'b0;
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    chk({tag, "_retired"}, 64'(if8.out_valid), 64'd0);
    chk({tag, "_c_kept"}, 64'(if8.c), e);
  endtask

  initial begin
    int acc;
    int outs;
    int cyc;
    logic [31:0] ra, rb;
    logic rs;

    rst = 1'b1;
    if8.in_valid = 1'b0;  if8.out_ready = 1'b0;
    if8.a = '0;           if8.b = '0;          if8.is_signed = 1'b0;
    if32.in_valid = 1'b0; if32.out_ready = 1'b0;
    if32.a = '0;          if32.b = '0;         if32.is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", 64'(if8.in_ready), 64'd1);
    chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
    chk("rst_busy", 64'(if8.busy), 64'd0);
    chk("rst_c", 64'(if8.c), 64'd0);
    chk("rst32_c", if32.c, 64'd0);

    do8(8'hFF, 8'hFF, 1'b1, 16'h0001, 0, "s_m1xm1");
    do8(8'h80, 8'h80, 1'b1, 16'h4000, 0, "s_minxmin");
    do8(8'h80, 8'h7F, 1'b1, 16'hC080, 0, "s_minxmax");
    do8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, "u_maxxmax");
    do8(8'h00, 8'hA5, 1'b0, 16'h0000, 0, "u_zero");
    do8(8'h5A, 8'hC3, 1'b1, 16'(model(32'h5A, 32'hC3, 1'b1, 8)), 10, "bp");

    // Abort during the third COMPUTE cycle
    if8.a = 8'h12; if8.b = 8'h34; if8.is_signed = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 64'(if8.in_ready), 64'd1);
    chk("abort_out_valid", 64'(if8.out_valid), 64'd0);
    chk("abort_c", 64'(if8.c), 64'd0);
    chk("abort_busy", 64'(if8.busy), 64'd0);
    do8(8'd3, 8'd5, 1'b0, 16'd15, 0, "post_abort");

    // N=32 random regression with handshake gaps; first two are corner cases
    acc = 0;
    outs = 0;
    cyc = 0;
    while ((acc < NRAND || q32.size() != 0) && cyc < BOUND) begin
      if (acc == 0) begin
        ra = 32'h8000_0000; rb = 32'h8000_0000; rs = 1'b1;
      end else if (acc == 1) begin
        ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; rs = 1'b0;
      end else begin
        ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
      end
      if32.a = ra;
      if32.b = rb;
      if32.is_signed = rs;
      if32.in_valid = (acc < NRAND) && ($urandom_range(0, 1) == 1);
      if32.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (if32.in_valid && if32.in_ready) begin
        if (acc == 0)      q32.push_back(64'h4000_0000_0000_0000);
        else if (acc == 1) q32.push_back(64'hFFFF_FFFE_0000_0001);
        else               q32.push_back(model(ra, rb, rs, 32));
        acc++;
      end
      if (if32.out_valid && if32.out_ready) begin
        outs++;
        if (q32.size() != 0) chk("rand_c", if32.c, q32.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    if32.in_valid = 1'b0;
    if32.out_ready = 1'b0;
    chk("rand_in_budget", 64'(cyc < BOUND), 64'd1);
    chk("rand_accepted", 64'(acc), 64'(NRAND));
    chk("rand_outputs", 64'(outs), 64'(acc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
